itim_assoc: RTL and testbench

- Parametrised successor to the direct-mapped instruction TIM controller: N-way set-associative instruction cache between fetch stage and backing instruction memory.
- Line size, set count and way count configurable; per-set round-robin replacement; single-cycle fence invalidate; uncached pass-through outside the TIM window.
- Sits between fetch unit (itim_* side) and bus/memory arbiter (imem_* side). Tag, data and replacement storage internal.

---
 rtl/itim_assoc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_itim_assoc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/itim_assoc.sv
`default_nettype none
// ============================================================================
// itim_assoc : N-way set-associative instruction TIM with round-robin refill,
//              fence invalidate and uncached bypass. Option: ITIM_PERF_CNT_EN.
// Revision   : 1.0
// ============================================================================
module itim_assoc #(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned DEPTH     = 6,
    parameter int unsigned WIDTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] TOP_ADDR  = 32'h8001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        itim_valid,
    input  logic        itim_fence,
    input  logic [31:0] itim_addr,
    output logic [31:0] itim_rdata,
    output logic        itim_ready,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    output logic        imem_instr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned SETS    = 1 << DEPTH;
    localparam int unsigned WORDS   = 1 << WIDTH;
    localparam int unsigned TAGW    = 30 - DEPTH - WIDTH;
    localparam int unsigned RRW     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_LSB = DEPTH + WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        UPDATE = 3'd3,
        BYPASS = 3'd4,
        FENCE  = 3'd5
    } state_t;

    state_t                      state, state_n;
    logic [31:2]                 addr_q;
    logic [TAGW-1:0]             req_tag;
    logic [DEPTH-1:0]            req_set;
    logic [WIDTH-1:0]            req_word;
    logic [DEPTH-1:0]            acc_set;
    logic                        accept;
    logic                        outside;
    logic [WAYS-1:0][SETS-1:0]   valid;
    logic [WAYS-1:0]             hit_vec;
    logic [WAYS-1:0][31:0]       way_word;
    logic                        hit;
    logic [31:0]                 hit_word;
    logic [RRW-1:0]              rr_cur;
    logic [RRW-1:0]              victim;
    logic                        victim_is_ptr;
    logic [RRW-1:0]              victim_q;
    logic                        from_ptr;
    logic [WIDTH-1:0]            cnt;
    logic [WORDS-1:0][31:0]      line_buf;
    logic [WORDS-1:0][31:0]      line_word;
    logic                        line_wr;
    logic                        imem_valid_n;
    logic [31:0]                 imem_addr_n;

    assign req_tag    = addr_q[31:TAG_LSB];
    assign req_set    = addr_q[TAG_LSB-1:WIDTH+2];
    assign req_word   = addr_q[WIDTH+1:2];
    assign acc_set    = itim_addr[TAG_LSB-1:WIDTH+2];
    assign outside    = (itim_addr < BASE_ADDR) || (itim_addr >= TOP_ADDR);
    assign imem_instr = 1'b1;
    assign hit        = |hit_vec;

    // Per-way storage: read address registered on accept, data valid in LOOKUP
    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            logic [TAGW-1:0]        tag_mem  [SETS];
            logic [WORDS-1:0][31:0] data_mem [SETS];
            logic [TAGW-1:0]        tag_rd;
            logic [WORDS-1:0][31:0] data_rd;

            always_ff @(posedge clk) begin
                if (accept) begin
                    tag_rd  <= tag_mem[acc_set];
                    data_rd <= data_mem[acc_set];
                end
                if (line_wr && !rst && (victim_q == RRW'(w))) begin
                    tag_mem[req_set]  <= req_tag;
                    data_mem[req_set] <= line_word;
                end
            end

            assign hit_vec[w]  = valid[w][req_set] && (tag_rd == req_tag);
            assign way_word[w] = data_rd[req_word];
        end
    endgenerate

    generate
        if (WAYS > 1) begin : g_rr
            logic [SETS-1:0][RRW-1:0] rr_ptr;
            always_ff @(posedge clk) begin
                if (rst || (state == FENCE)) begin
                    rr_ptr <= '0;
                end else if (line_wr && from_ptr) begin
                    rr_ptr[req_set] <= rr_ptr[req_set] + 1'b1;
                end
            end
            assign rr_cur = rr_ptr[req_set];
        end else begin : g_rr_none
            logic unused_rr;
            assign unused_rr = from_ptr;
            assign rr_cur    = '0;
        end
    endgenerate

    // Prefer the lowest invalid way; fall back to the round-robin pointer
    always_comb begin
        victim        = rr_cur;
        victim_is_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][req_set]) begin
                victim        = RRW'(w);
                victim_is_ptr = 1'b0;
            end
        end
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_word = hit_word | way_word[w];
        end
    end

    always_comb begin
        line_word            = line_buf;
        line_word[WORDS-1]   = imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        itim_ready   = 1'b0;
        itim_rdata   = '0;
        imem_valid_n = imem_valid;
        imem_addr_n  = imem_addr;
        line_wr      = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: ;
            LOOKUP: begin
                if (hit) begin
                    itim_ready = 1'b1;
                    itim_rdata = hit_word;
                    state_n    = IDLE;
                end else begin
                    state_n      = REFILL;
                    imem_valid_n = 1'b1;
                    imem_addr_n  = {addr_q[31:WIDTH+2], {(WIDTH+2){1'b0}}};
                end
            end
            REFILL: begin
                if (imem_ready) begin
                    imem_addr_n = imem_addr + 32'd4;
                    if (cnt == '1) begin
                        line_wr      = 1'b1;
                        state_n      = UPDATE;
                        imem_valid_n = 1'b0;
                    end
                end
            end
            UPDATE: begin
                itim_ready = 1'b1;
                itim_rdata = line_buf[req_word];
                state_n    = IDLE;
            end
            BYPASS: begin
                if (imem_ready) begin
                    itim_ready   = 1'b1;
                    itim_rdata   = imem_rdata;
                    state_n      = IDLE;
                    imem_valid_n = 1'b0;
                end
            end
            FENCE: begin
                itim_ready = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A new request is taken when idle or in any response cycle
        if (itim_valid && ((state == IDLE) || itim_ready)) begin
            accept = 1'b1;
            if (itim_fence) begin
                state_n = FENCE;
            end else if (outside) begin
                state_n      = BYPASS;
                imem_valid_n = 1'b1;
                imem_addr_n  = itim_addr;
            end else begin
                state_n = LOOKUP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            imem_valid <= 1'b0;
            imem_addr  <= '0;
            addr_q     <= '0;
            victim_q   <= '0;
            from_ptr   <= 1'b0;
            cnt        <= '0;
            line_buf   <= '0;
        end else begin
            imem_valid <= imem_valid_n;
            imem_addr  <= imem_addr_n;
            if (accept) addr_q <= itim_addr[31:2];
            if ((state == LOOKUP) && !hit) begin
                victim_q <= victim;
                from_ptr <= victim_is_ptr;
                cnt      <= '0;
            end
            if ((state == REFILL) && imem_ready) begin
                line_buf[cnt] <= imem_rdata;
                cnt           <= cnt + 1'b1;
            end
            if (line_wr) valid[victim_q][req_set] <= 1'b1;
            if (state == FENCE) valid <= '0;
        end
    end

`ifdef ITIM_PERF_CNT_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_q  <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
        end
    end
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_itim_assoc.sv
`default_nettype none
// tb_itim_assoc: directed fetches against itim_assoc; a scoreboard queue holds
// the expected word, refill beat count and first backing address per request.
module tb_itim_assoc;
`ifdef ITIM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        itim_valid;
    logic        itim_fence;
    logic [31:0] itim_addr;
    logic [31:0] itim_rdata;
    logic        itim_ready;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_instr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    itim_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .itim_valid (itim_valid),
        .itim_fence (itim_fence),
        .itim_addr  (itim_addr),
        .itim_rdata (itim_rdata),
        .itim_ready (itim_ready),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          beats;
        logic [31:0] ia;
    } exp_t;

    exp_t q[$];
    int   resp_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Backing memory: the 0x80000100 line holds 0xA0+k, everything else addr^FFFF0000
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a[31:4] == 28'h8000010) return 32'hA0 + {28'd0, a[3:2]};
        return a ^ 32'hFFFF_0000;
    endfunction

    // Responder: one beat every other cycle while imem_valid is held
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ready) begin
                imem_ready = 1'b0;
            end else if (imem_valid) begin
                imem_ready = 1'b1;
                imem_rdata = mem(imem_addr);
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats = 0;
            end else begin
                if (imem_valid && imem_ready) begin
                    if (beats == 0 && q.size() > 0) chk("imem_addr", imem_addr, q[0].ia);
                    beats++;
                end
                if (itim_ready) begin
                    resp_cyc.push_back(cyc);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=%08h required=none", itim_rdata);
                    end else begin
                        e = q.pop_front();
                        chk("rdata", itim_rdata, e.rdata);
                        chk("beats", beats, e.beats);
                    end
                    beats = 0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic f, input logic [31:0] d,
                         input int b, input logic [31:0] ia);
        int   g;
        exp_t e;
        g = 0;
        do begin
            @(negedge clk);
            #2;
            g++;
        end while (q.size() != 0 && g < 300);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=%0d required=0", q.size());
            q.delete();
        end
        itim_valid = 1'b1;
        itim_addr  = a;
        itim_fence = f;
        e.rdata = d;
        e.beats = b;
        e.ia    = ia;
        q.push_back(e);
        @(posedge clk);
        #1;
        itim_valid = 1'b0;
        itim_fence = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 300) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int base;
        int g;
        rst        = 1'b1;
        itim_valid = 1'b0;
        itim_fence = 1'b0;
        itim_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, itim_ready}, 32'd0);
        chk("rst_rdata", itim_rdata, 32'd0);
        chk("rst_imem_valid", {31'd0, imem_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("imem_instr", {31'd0, imem_instr}, 32'd1);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;

        issue(32'h8000_0104, 1'b0, 32'h0000_00A1, 4, 32'h8000_0100);  // cold miss
        issue(32'h8000_010C, 1'b0, 32'h0000_00A3, 0, 32'h0);          // hit
        issue(32'h8000_1100, 1'b0, 32'h7FFF_1100, 4, 32'h8000_1100);  // fills way 1
        issue(32'h8000_2100, 1'b0, 32'h7FFF_2100, 4, 32'h8000_2100);  // evicts way 0
        issue(32'h8000_1100, 1'b0, 32'h7FFF_1100, 0, 32'h0);          // hit
        issue(32'h8000_0108, 1'b0, 32'h0000_00A2, 4, 32'h8000_0100);  // evicted, evicts way 1
        drain();
        chk("hit_cnt_a", hit_cnt, PERF ? 32'd2 : 32'd0);
        chk("miss_cnt_a", miss_cnt, PERF ? 32'd4 : 32'd0);
        issue(32'h8000_2104, 1'b0, 32'h7FFF_2104, 0, 32'h0);          // survivor hit

        issue(32'h0000_1000, 1'b0, 32'hFFFF_1000, 1, 32'h0000_1000);  // bypass
        issue(32'h0000_1000, 1'b0, 32'hFFFF_1000, 1, 32'h0000_1000);  // bypass again
        issue(32'h8001_0000, 1'b0, 32'h7FFE_0000, 1, 32'h8001_0000);  // TOP exclusive
        issue(32'h7FFF_FFFC, 1'b0, 32'h8000_FFFC, 1, 32'h7FFF_FFFC);  // below BASE
        issue(32'h8000_FFFC, 1'b0, 32'h7FFF_FFFC, 4, 32'h8000_FFF0);  // last cacheable word

        issue(32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0);          // fence
        issue(32'h8000_0100, 1'b0, 32'h0000_00A0, 4, 32'h8000_0100);  // refill after fence

        drain();
        base = resp_cyc.size();
        issue(32'h8000_0104, 1'b0, 32'h0000_00A1, 0, 32'h0);
        issue(32'h8000_0108, 1'b0, 32'h0000_00A2, 0, 32'h0);
        issue(32'h8000_010C, 1'b0, 32'h0000_00A3, 0, 32'h0);
        issue(32'h8000_0100, 1'b0, 32'h0000_00A0, 0, 32'h0);
        drain();
        if (resp_cyc.size() >= base + 4)
            chk("b2b_span", resp_cyc[base+3] - resp_cyc[base], 32'd3);
        else
            chk("b2b_count", resp_cyc.size() - base, 32'd4);

        issue(32'h8000_0104, 1'b0, 32'h0000_00A1, 0, 32'h0);          // hit
        issue(32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0);          // fence in hit cycle
        issue(32'h8000_0104, 1'b0, 32'h0000_00A1, 4, 32'h8000_0100);
        drain();
        chk("hit_cnt_b", hit_cnt, PERF ? 32'd8 : 32'd0);
        chk("miss_cnt_b", miss_cnt, PERF ? 32'd7 : 32'd0);

        // Reset in the middle of a refill
        issue(32'h8000_2108, 1'b0, 32'h7FFF_2108, 4, 32'h8000_2100);
        g = 0;
        while (beats < 2 && g < 100) begin
            @(negedge clk);
            #2;
            g++;
        end
        chk("beats_before_rst", beats, 32'd2);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #2;
        chk("rst_abort_imem_valid", {31'd0, imem_valid}, 32'd0);
        chk("rst_abort_ready", {31'd0, itim_ready}, 32'd0);
        chk("rst_abort_hit_cnt", hit_cnt, 32'd0);
        chk("rst_abort_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        issue(32'h8000_2108, 1'b0, 32'h7FFF_2108, 4, 32'h8000_2100);
        issue(32'h8000_0104, 1'b0, 32'h0000_00A1, 4, 32'h8000_0100);  // valid bits cleared
        drain();
        chk("miss_cnt_c", miss_cnt, PERF ? 32'd2 : 32'd0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
